ysyx_24080006_axi_sram_slv: RTL and testbench
=============================================

Name: ysyx_24080006_axi_sram_slv

Overview:
AXI4 slave responder: the memory end of the core's AXI master interface (IFU/LSU/icache refill), backed by an internal word array. It accepts read and write bursts on fully independent channels, with a configurable read latency. It is used as the sim-mode main memory and as the protocol checker target for the core's AXI master.

Parameters:
DEPTH_WORDS, 4096, number of 32-bit words in the array (power of two).
BASE_ADDR, 32'h8000_0000, byte address mapped to word 0.
RD_LATENCY, 2, idle cycles between AR handshake and first rvalid (0 allowed).

Ports:
clk_i  in  1  clock.
rst_ni  in  1  synchronous, active-low reset.
w_m2s_i  in  85  axi_w_m2s_t: awvalid/awaddr/awlen/awsize/awburst, wvalid/wdata/wstrb/wlast, bready.
w_s2m_o  out  3  axi_w_s2m_t: awready, wready, bvalid.
r_m2s_i  in  47  axi_r_m2s_t: arvalid/araddr/arlen/arsize/arburst, rready.
r_s2m_o  out  35  axi_r_s2m_t: arready, rvalid, rdata, rlast.
err_o  out  1  sticky: out-of-range access or wlast/awlen mismatch seen.

Behaviour:
- Reset (rst_ni=0 at posedge): both FSMs go to IDLE; rvalid=0, rlast=0, rdata=0, wready=0, bvalid=0, err_o=0; arready=awready=1 from the next cycle. Array contents are not reset. A reset mid-burst abandons the burst with no response.
- Word index = (addr-BASE_ADDR)>>2. Address is in range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS. Any in-range check is done per beat.
- Beat address advance:
  - FIXED (2'b00): no change.
  - INCR (2'b01) and reserved 2'b11: +(1<<awsize/arsize).
  - WRAP (2'b10): increment, wrapping inside an aligned window of (len+1)<<size bytes.
- rdata is always the full aligned word; the master selects lanes.
- Read FSM R_IDLE/R_WAIT/R_DATA:
  - R_IDLE: arready=1. On arvalid&&arready, latch addr, len, size and burst; beat=0; cnt=RD_LATENCY. Go to R_WAIT, or to R_DATA if RD_LATENCY=0.
  - R_WAIT: arready=0; cnt decrements each cycle. At cnt==1, register rdata=mem[idx] and go to R_DATA.
  - R_DATA: rvalid=1; rlast=(beat==len). rdata and rlast are held stable while rvalid&&!rready.
  - On rvalid&&rready with !rlast: beat++, advance addr, and register the next rdata so it is valid the next cycle (back-to-back beats, no bubble).
  - On rvalid&&rready with rlast: rvalid=0, return to R_IDLE. A new AR is accepted one cycle later.
  - Out-of-range read beat: rdata=0, err_o set.
- Write FSM W_IDLE/W_DATA/W_RESP:
  - W_IDLE: awready=1, wready=0. On the AW handshake, latch fields; beat=0; go to W_DATA.
  - W_DATA: wready=1. Each wvalid&&wready writes the bytes with wstrb[i]=1 into mem[idx][8i+7:8i], then beat++ and addr advances. An out-of-range write is dropped and sets err_o.
  - The burst ends on the beat where beat==awlen, regardless of wlast. If wlast differs from (beat==awlen) on any beat, set err_o.
  - W_RESP: bvalid=1 (first asserted the cycle after the last W beat), wready=0, awready=0. Hold until bready, then go to W_IDLE.
  - W data presented before the AW handshake is not accepted (wready=0 in W_IDLE).
- Simultaneous events:
  - Read and write channels run concurrently.
  - If a write and a read-data register load hit the same word in the same cycle, the read captures the old value. The write is visible to any load on a later cycle.
- Address/length arithmetic is 32-bit unsigned wrap-around; len is 8 bits, giving up to 256 beats.

Optional Feature:
AXI_SLV_RAND_DELAY_EN
- Defined: a 16-bit LFSR (seed 16'hACE1 on reset, stepping every cycle) inserts stalls.
  - arready/awready are deasserted in IDLE when lfsr[0]=1.
  - wready is dropped for a beat when lfsr[1]=1.
  - Each R beat and bvalid get an extra 0-3 cycle delay from lfsr[3:2] before assertion.
  - Handshake stability rules above still hold.
- Undefined: no LFSR; timing is exactly as in Behaviour.

Test Plan:
- Single read, RD_LATENCY=2: write word 0 = 32'h1234_5678, then araddr=32'h8000_0000, arlen=0, rready=1. Required: rvalid rises exactly 3 cycles after the AR handshake; rdata=32'h1234_5678; rlast=1.
- INCR write burst: awaddr=32'h8000_0010, awlen=3, size=2, wdata=1..4, wstrb=4'hF. Required: bvalid 1 cycle after the 4th beat. A following read burst of len 3 returns 1,2,3,4 on consecutive cycles with rlast only on beat 4.
- Byte strobes: word=32'hFFFF_FFFF, then write 32'h0000_AB00 with wstrb=4'b0010. Required: readback 32'hFFFF_ABFF.
- WRAP read: araddr=32'h8000_0038, len=3, size=2. Required: beats come from offsets 0x38, 0x3C, 0x30, 0x34.
- Backpressure and errors:
  - rready low for 5 cycles mid-burst: rdata and rlast hold stable.
  - bready delayed 4 cycles: bvalid holds.
  - Read at 32'h7FFF_FFFC: rdata=0 and err_o=1.
  - wlast=1 on beat 1 of an awlen=2 burst: err_o=1, and the burst still takes 3 beats.
- Reset mid-burst: assert rst_ni=0 during beat 2 of a 4-beat read. Required: rvalid=0 the next cycle and arready=1 after release; a subsequent burst completes normally.

Source files
------------

// File: rtl/ysyx_24080006_axi_sram_slv.sv
// ysyx_24080006_axi_sram_slv: AXI4 SRAM slave with independent read/write burst FSMs.
// Define AXI_SLV_RAND_DELAY_EN for LFSR-driven ready/valid stalls.
module ysyx_24080006_axi_sram_slv #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned RD_LATENCY  = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [84:0] w_m2s_i,
    output logic [2:0]  w_s2m_o,
    input  logic [46:0] r_m2s_i,
    output logic [34:0] r_s2m_o,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic        awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [31:0] awaddr, wdata, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic        ar_stall, aw_stall, w_stall;
    logic [1:0]  dly_seed;

    assign {awvalid, awaddr, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready} = w_m2s_i;
    assign {arvalid, araddr, arlen, arsize, arburst, rready} = r_m2s_i;

    function automatic logic in_range(input logic [31:0] a);
        return (a - BASE_ADDR) < SPAN;
    endfunction

    function automatic logic [AW-1:0] idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] step, mask;
        step = 32'd1 << size;
        mask = ((32'(len) + 32'd1) << size) - 32'd1;
        return burst == 2'b00 ? a : burst == 2'b10 ? (a & ~mask) | ((a + step) & mask) : a + step;
    endfunction

`ifdef AXI_SLV_RAND_DELAY_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk_i)
        lfsr <= !rst_ni ? 16'hACE1 : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign ar_stall = lfsr[0];
    assign aw_stall = lfsr[0];
    assign w_stall  = lfsr[1];
    assign dly_seed = lfsr[3:2];
`else
    assign ar_stall = 1'b0;
    assign aw_stall = 1'b0;
    assign w_stall  = 1'b0;
    assign dly_seed = 2'd0;
`endif

    logic [31:0] mem [DEPTH_WORDS];

    r_state_t    r_state;
    logic [31:0] r_addr, rdata, ld_addr, ld_word, r_next;
    logic [7:0]  r_len, r_beat;
    logic [2:0]  r_size;
    logic [1:0]  r_burst, rdly;
    logic [15:0] r_cnt;
    logic        arready_q, rvalid_q, rlast, r_err;

    // One shared load port: AR address on accept, latched address while waiting, next beat otherwise.
    assign r_next  = next_addr(r_addr, r_len, r_size, r_burst);
    assign ld_addr = r_state == R_IDLE ? araddr : r_state == R_WAIT ? r_addr : r_next;
    assign ld_word = in_range(ld_addr) ? mem[idx(ld_addr)] : 32'd0;
    assign arready = arready_q && !ar_stall;
    assign rvalid  = rvalid_q && rdly == 2'd0;
    assign r_s2m_o = {arready, rvalid, rdata, rlast};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast     <= 1'b0;
            rdata     <= 32'd0;
            r_err     <= 1'b0;
            rdly      <= 2'd0;
            r_beat    <= 8'd0;
            r_cnt     <= 16'd0;
        end else begin
            case (r_state)
                R_IDLE: if (arvalid && arready) begin
                    r_addr    <= araddr;
                    r_len     <= arlen;
                    r_size    <= arsize;
                    r_burst   <= arburst;
                    r_beat    <= 8'd0;
                    r_cnt     <= 16'(RD_LATENCY);
                    arready_q <= 1'b0;
                    if (RD_LATENCY == 0) begin
                        rdata    <= ld_word;
                        r_err    <= r_err | !in_range(ld_addr);
                        rvalid_q <= 1'b1;
                        rlast    <= arlen == 8'd0;
                        rdly     <= dly_seed;
                        r_state  <= R_DATA;
                    end else begin
                        r_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    r_cnt <= r_cnt - 16'd1;
                    if (r_cnt == 16'd1) begin
                        rdata    <= ld_word;
                        r_err    <= r_err | !in_range(ld_addr);
                        rvalid_q <= 1'b1;
                        rlast    <= r_len == 8'd0;
                        rdly     <= dly_seed;
                        r_state  <= R_DATA;
                    end
                end
                R_DATA: if (rdly != 2'd0) begin
                    rdly <= rdly - 2'd1;
                end else if (rready) begin
                    if (rlast) begin
                        rvalid_q  <= 1'b0;
                        rlast     <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end else begin
                        r_beat <= r_beat + 8'd1;
                        r_addr <= r_next;
                        rdata  <= ld_word;
                        r_err  <= r_err | !in_range(ld_addr);
                        rlast  <= (r_beat + 8'd1) == r_len;
                        rdly   <= dly_seed;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    w_state_t    w_state;
    logic [31:0] w_addr;
    logic [7:0]  w_len, w_beat;
    logic [2:0]  w_size;
    logic [1:0]  w_burst, bdly;
    logic        awready_q, wready_q, bvalid_q, w_err, w_hs;

    assign awready = awready_q && !aw_stall;
    assign wready  = wready_q && !w_stall;
    assign bvalid  = bvalid_q && bdly == 2'd0;
    assign w_hs    = wvalid && wready;
    assign w_s2m_o = {awready, wready, bvalid};
    assign err_o   = r_err | w_err;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            w_err     <= 1'b0;
            bdly      <= 2'd0;
            w_beat    <= 8'd0;
        end else begin
            case (w_state)
                W_IDLE: if (awvalid && awready) begin
                    w_addr    <= awaddr;
                    w_len     <= awlen;
                    w_size    <= awsize;
                    w_burst   <= awburst;
                    w_beat    <= 8'd0;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b1;
                    w_state   <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    if (!in_range(w_addr) || wlast != (w_beat == w_len))
                        w_err <= 1'b1;
                    if (w_beat == w_len) begin
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        bdly     <= dly_seed;
                        w_state  <= W_RESP;
                    end else begin
                        w_beat <= w_beat + 8'd1;
                        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                    end
                end
                W_RESP: if (bdly != 2'd0) begin
                    bdly <= bdly - 2'd1;
                end else if (bready) begin
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                    w_state   <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Array is never reset; a same-cycle read load sees the pre-write word.
    always_ff @(posedge clk_i) begin
        if (rst_ni && w_hs && in_range(w_addr))
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) mem[idx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_ysyx_24080006_axi_sram_slv.sv
// tb_ysyx_24080006_axi_sram_slv: directed + randomized bursts against a word-array model.
module tb_ysyx_24080006_axi_sram_slv;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] SPAN = 32'd4096 * 4;
    localparam int RD_LAT = 2;

    logic clk = 1'b0, rst_ni = 1'b0;
    logic awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] awaddr = 0, wdata = 0, araddr = 0;
    logic [7:0]  awlen = 0, arlen = 0;
    logic [2:0]  awsize = 0, arsize = 0;
    logic [1:0]  awburst = 0, arburst = 0;
    logic [3:0]  wstrb = 0;
    logic [84:0] w_m2s;
    logic [46:0] r_m2s;
    logic [2:0]  w_s2m;
    logic [34:0] r_s2m;
    logic        err_o, awready, wready, bvalid, arready, rvalid, rlast;
    logic [31:0] rdata;

    int checks = 0, errors = 0;
    logic exp_err = 1'b0;
    logic [31:0] mm [4096];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic [31:0] rd_log [256];

    assign w_m2s = {awvalid, awaddr, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready};
    assign r_m2s = {arvalid, araddr, arlen, arsize, arburst, rready};
    assign {awready, wready, bvalid} = w_s2m;
    assign {arready, rvalid, rdata, rlast} = r_s2m;

    ysyx_24080006_axi_sram_slv #(.DEPTH_WORDS(4096), .BASE_ADDR(BASE), .RD_LATENCY(RD_LAT)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .w_m2s_i(w_m2s), .w_s2m_o(w_s2m),
        .r_m2s_i(r_m2s), .r_s2m_o(r_s2m), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beat address from burst start and beat number, not by stepping.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst, input int i);
        logic [31:0] step, wsz, base;
        step = 32'd1 << size;
        if (burst == 2'b00) return a;
        if (burst == 2'b10) begin
            wsz  = (32'(len) + 32'd1) * step;
            base = a - (a % wsz);
            return base + ((a - base + 32'(i) * step) % wsz);
        end
        return a + 32'(i) * step;
    endfunction

    task automatic do_reset();
        rst_ni = 0; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        tick();
        tick();
        rst_ni = 1;
        exp_err = 0;
        tick();
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int early, input int bdelay);
        int n;
        logic [31:0] ba;
        awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1;
        n = 0;
        while (!awready && n < 100) begin tick(); n++; end
        chk("awready", 32'(awready), 1);
        tick();
        awvalid = 0;
        for (int i = 0; i <= int'(len); i++) begin
            ba = beat_addr(a, len, size, burst, i);
            wvalid = 1; wdata = wd[i]; wstrb = ws[i];
            wlast = (early >= 0) ? (i == early) : (i == int'(len));
            n = 0;
            while (!wready && n < 100) begin tick(); n++; end
            chk("wready", 32'(wready), 1);
            tick();
            if (ba - BASE < SPAN) begin
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) mm[int'((ba - BASE) >> 2)][8*b +: 8] = wd[i][8*b +: 8];
            end else exp_err = 1;
            if (wlast != (i == int'(len))) exp_err = 1;
            chk("bvalid_beat", 32'(bvalid), 32'(i == int'(len)));
        end
        wvalid = 0; wlast = 0;
        for (int k = 0; k < bdelay; k++) begin
            chk("bvalid_hold", 32'(bvalid), 1);
            tick();
        end
        bready = 1;
        chk("bvalid", 32'(bvalid), 1);
        tick();
        bready = 0;
        chk("bvalid_clr", 32'(bvalid), 0);
        chk("err_w", 32'(err_o), 32'(exp_err));
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int gap_beat, input int gap_len);
        int n;
        logic [31:0] ba, exp;
        araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1;
        n = 0;
        while (!arready && n < 100) begin tick(); n++; end
        chk("arready", 32'(arready), 1);
        tick();
        arvalid = 0;
        n = 1;
        while (!rvalid && n < 100) begin tick(); n++; end
        chk("rd_latency", 32'(n), 32'(RD_LAT + 1));
        for (int i = 0; i <= int'(len); i++) begin
            ba = beat_addr(a, len, size, burst, i);
            if (ba - BASE < SPAN) exp = mm[int'((ba - BASE) >> 2)];
            else begin exp = 0; exp_err = 1; end
            chk("rvalid", 32'(rvalid), 1);
            chk("rdata", rdata, exp);
            chk("rlast", 32'(rlast), 32'(i == int'(len)));
            rd_log[i] = rdata;
            if (i == gap_beat) begin
                rready = 0;
                for (int k = 0; k < gap_len; k++) begin
                    tick();
                    chk("rvalid_hold", 32'(rvalid), 1);
                    chk("rdata_hold", rdata, exp);
                    chk("rlast_hold", 32'(rlast), 32'(i == int'(len)));
                end
            end
            rready = 1;
            tick();
        end
        rready = 0;
        chk("rvalid_end", 32'(rvalid), 0);
        chk("err_r", 32'(err_o), 32'(exp_err));
    endtask

    initial begin
        int w, b, l;
        logic [7:0] len;
        do_reset();
        chk("rst_arready", 32'(arready), 1);
        chk("rst_awready", 32'(awready), 1);
        chk("rst_wready", 32'(wready), 0);
        chk("rst_bvalid", 32'(bvalid), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rlast", 32'(rlast), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", 32'(err_o), 0);

        wd[0] = 32'h1234_5678; ws[0] = 4'hF;
        axi_write(32'h8000_0000, 0, 2, 1, -1, 0);
        axi_read(32'h8000_0000, 0, 2, 1, -1, 0);
        chk("single_rd", rd_log[0], 32'h1234_5678);

        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        axi_write(32'h8000_0010, 3, 2, 1, -1, 0);
        axi_read(32'h8000_0010, 3, 2, 1, -1, 0);
        for (int i = 0; i < 4; i++) chk("incr_rd", rd_log[i], 32'(i + 1));

        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        axi_write(32'h8000_0040, 0, 2, 1, -1, 0);
        wd[0] = 32'h0000_AB00; ws[0] = 4'b0010;
        axi_write(32'h8000_0040, 0, 2, 1, -1, 4);
        axi_read(32'h8000_0040, 0, 2, 1, -1, 0);
        chk("strobe_rd", rd_log[0], 32'hFFFF_ABFF);

        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        axi_write(32'h8000_0030, 3, 2, 1, -1, 0);
        axi_read(32'h8000_0038, 3, 2, 2, -1, 0);
        chk("wrap0", rd_log[0], 32'hA2);
        chk("wrap1", rd_log[1], 32'hA3);
        chk("wrap2", rd_log[2], 32'hA0);
        chk("wrap3", rd_log[3], 32'hA1);

        axi_read(32'h8000_0010, 3, 2, 1, 1, 5);

        for (int i = 0; i < 64; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        axi_write(32'h8000_0100, 63, 2, 1, -1, 0);
        for (int t = 0; t < 40; t++) begin
            w = $urandom_range(0, 55);
            b = $urandom_range(0, 2);
            l = $urandom_range(0, 7);
            len = (b == 2) ? 8'((1 << $urandom_range(1, 3)) - 1) : 8'(l);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
                axi_write(32'h8000_0100 + 32'(w) * 4, len, 2, 2'(b), -1, $urandom_range(0, 3));
            end else begin
                axi_read(32'h8000_0100 + 32'(w) * 4, len, 2, 2'(b), $urandom_range(0, 8), $urandom_range(1, 3));
            end
        end

        araddr = 32'h8000_0010; arlen = 3; arsize = 2; arburst = 1; arvalid = 1;
        tick();
        arvalid = 0;
        for (int n = 0; n < 20 && !rvalid; n++) tick();
        rready = 1;
        tick();
        rready = 0;
        chk("pre_rst_rvalid", 32'(rvalid), 1);
        rst_ni = 0;
        tick();
        chk("mid_rst_rvalid", 32'(rvalid), 0);
        rst_ni = 1;
        exp_err = 0;
        tick();
        chk("post_rst_arready", 32'(arready), 1);
        axi_read(32'h8000_0010, 3, 2, 1, -1, 0);

        axi_read(32'h7FFF_FFFC, 0, 2, 1, -1, 0);
        chk("oor_rdata", rd_log[0], 0);
        chk("oor_err", 32'(err_o), 1);

        do_reset();
        chk("err_cleared", 32'(err_o), 0);
        for (int i = 0; i < 3; i++) begin wd[i] = 32'hC0 + 32'(i); ws[i] = 4'hF; end
        axi_write(32'h8000_0080, 2, 2, 1, 1, 0);
        chk("wlast_err", 32'(err_o), 1);
        axi_read(32'h8000_0080, 2, 2, 1, -1, 0);
        chk("wlast_beat2", rd_log[2], 32'hC2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
